scan_chain_tester: RTL and testbench

SCAN_CHAIN_TESTER -- requirements
Module: scan_chain_tester

---
 rtl/scan_chain_tester.sv | 139 +++++++++++++
 tb/tb_scan_chain_tester.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_tester.sv
// Drives an external scan chain through load / capture / unload and reports the response.
// Define SCAN_TESTER_COMPARE_EN to include the expected register and pass comparator.
module scan_chain_tester #(
  parameter int CHAIN_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 pass
);

  localparam int CW = $clog2(CHAIN_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CHAIN_LEN-1:0] MSB_ONE = {1'b1, {(CHAIN_LEN-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pattern_q, pattern_d;
  logic [CHAIN_LEN-1:0] response_q, response_d;
  logic                 accept;
  logic                 finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pattern_q  <= '0;
      response_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pattern_q  <= pattern_d;
      response_q <= response_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pattern_d  = pattern_q;
    response_d = response_q;
    scan_en    = 1'b0;
    scan_in    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept     = 1'b1;
          pattern_d  = pattern;
          response_d = '0;
          cnt_d      = '0;
          state_d    = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        // MSB first: the bit at position CHAIN_LEN-1-cnt goes out this cycle
        scan_en = 1'b1;
        scan_in = |(pattern_q & (MSB_ONE >> cnt_q));
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPTURE: begin
        cnt_d   = '0;
        state_d = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        scan_en    = 1'b1;
        response_d = {response_q[CHAIN_LEN-2:0], scan_out};
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign response = response_q;

`ifdef SCAN_TESTER_COMPARE_EN
  logic [CHAIN_LEN-1:0] expected_q;
  logic                 pass_q;

  // Compare against the final shifted value so pass is valid together with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_q <= '0;
      pass_q     <= 1'b0;
    end else if (accept) begin
      expected_q <= expected;
      pass_q     <= 1'b0;
    end else if (finish) begin
      pass_q <= (response_d == expected_q);
    end
  end

  assign pass = pass_q;
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_tester.sv
// Directed bench for scan_chain_tester with a behavioural 4-flop chain and a transaction-level model.
module tb_scan_chain_tester;
  localparam int N = 4;
`ifdef SCAN_TESTER_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] pattern = '0;
  logic [N-1:0] expected = '0;
  logic         scan_en, scan_in, scan_out, busy, done, pass;
  logic [N-1:0] response;

  logic [N-1:0] chain_q = '0;
  logic         hold_mode = 1'b0;
  logic [N-1:0] dval = 4'hA;

  int n_checks = 0;
  int n_fail = 0;

  scan_chain_tester #(.CHAIN_LEN(N)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .expected(expected),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out), .busy(busy),
    .done(done), .response(response), .pass(pass)
  );

  always #5 clk = ~clk;

  // The attached chain: shifts toward q[N-1] under scan_en, otherwise loads d
  assign scan_out = chain_q[N-1];
  always @(posedge clk)
    chain_q <= scan_en ? {chain_q[N-2:0], scan_in} : (hold_mode ? chain_q : dval);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a test occupies 2N+2 cycles after the accepting edge
  bit           m_active = 1'b0;
  int           m_t = 0;
  logic [N-1:0] m_pat = '0, m_exp = '0, m_resp = '0;
  logic         m_pass = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_resp   <= '0;
      m_pass   <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_pat    <= pattern;
        m_exp    <= expected;
      end
    end else if (m_t == 2*N+1) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
      if (m_t == 2*N) begin
        m_resp <= hold_mode ? m_pat : dval;
        m_pass <= CMP && ((hold_mode ? m_pat : dval) == m_exp);
      end
    end
  end

  always @(negedge clk) begin
    logic e_sin, e_sout, e_done, e_si;
    int   idx;
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_scan_en", scan_en, 0);
      check("rst_scan_in", scan_in, 0);
      check("rst_response", response, 0);
      check("rst_pass", pass, 0);
    end else begin
      e_sin  = m_active && (m_t < N);
      e_sout = m_active && (m_t >= N+1) && (m_t <= 2*N);
      e_done = m_active && (m_t == 2*N+1);
      idx    = N - 1 - m_t;
      e_si   = e_sin ? m_pat[idx[1:0]] : 1'b0;
      check("busy", busy, m_active);
      check("done", done, e_done);
      check("scan_en", scan_en, e_sin || e_sout);
      check("scan_in", scan_in, e_si);
      if (!m_active || e_done) begin
        check("response", response, m_resp);
        check("pass", pass, m_pass);
      end
    end
  end

  task automatic run_test(input logic [N-1:0] pat, input logic [N-1:0] exp, input bit hold,
                          input bit restart, output int lat, output logic [N-1:0] si_seq,
                          output logic [N-1:0] qcap);
    hold_mode = hold;
    lat = -1;
    si_seq = '0;
    qcap = '0;
    @(posedge clk); #2;
    pattern = pat; expected = exp; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; pattern = ~pat; expected = ~exp;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c < N) si_seq[N-1-c] = scan_in;
      if (c == N) qcap = chain_q;
      if (restart && c == 2) begin start = 1'b1; pattern = 4'hF; end
      if (restart && c == 3) start = 1'b0;
      if (done) begin lat = c; break; end
    end
    check("done_timeout", lat >= 0, 1);
    $display("test pat=%h exp=%h hold=%0d restart=%0d: scan_in=%h q_capture=%h latency=%0d response=%h pass=%0d",
             pat, exp, hold, restart, si_seq, qcap, lat, response, pass);
  endtask

  initial begin
    int lat, dones, last_done, cyc;
    logic [N-1:0] si, qc;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_response", response, 0);

    // Functional d = A, matching expectation
    run_test(4'h5, 4'hA, 1'b0, 1'b0, lat, si, qc);
    check("s1_scan_in_seq", si, 4'h5);
    check("s1_q_at_capture", qc, 4'h5);
    check("s1_latency", lat, 9);
    check("s1_response", response, 4'hA);
    check("s1_pass", pass, CMP ? 1 : 0);

    // Mismatching expectation
    run_test(4'h5, 4'h3, 1'b0, 1'b0, lat, si, qc);
    check("s2_response", response, 4'hA);
    check("s2_pass", pass, 0);

    // Hold chain: response must reproduce the pattern in order
    run_test(4'hC, 4'hC, 1'b1, 1'b0, lat, si, qc);
    check("s3_scan_in_seq", si, 4'hC);
    check("s3_response", response, 4'hC);
    check("s3_pass", pass, CMP ? 1 : 0);

    // Restart attempt while busy
    run_test(4'h5, 4'hA, 1'b0, 1'b1, lat, si, qc);
    check("s4_scan_in_seq", si, 4'h5);
    check("s4_latency", lat, 9);
    dones = 0;
    repeat (15) begin @(negedge clk); if (done) dones++; end
    check("s4_extra_dones", dones, 0);

    // Reset in the middle of unloading
    @(posedge clk); #2;
    pattern = 4'h5; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("s5_busy_now", busy, 0);
    check("s5_scan_en_now", scan_en, 0);
    check("s5_response_now", response, 0);
    dones = 0;
    repeat (5) begin @(negedge clk); if (done) dones++; end
    check("s5_no_done", dones, 0);
    @(posedge clk); #2 rst = 1'b0;
    run_test(4'h5, 4'hA, 1'b0, 1'b0, lat, si, qc);
    check("s5_latency_after_rst", lat, 9);
    check("s5_response_after_rst", response, 4'hA);

    // Start held high: back-to-back tests
    hold_mode = 1'b0;
    @(posedge clk); #2;
    pattern = 4'h9; expected = 4'hA; start = 1'b1;
    dones = 0; last_done = -1; cyc = 0;
    repeat (50) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last_done >= 0) check("s6_period", cyc - last_done, 11);
        last_done = cyc;
        dones++;
      end
    end
    check("s6_done_count", dones >= 4, 1);
    $display("test held start: %0d done pulses", dones);
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
